// File: rtl/bitfusion_pkg.sv
// Shared constants, precision modes and helpers for the bit-fusion operand path.
package bitfusion_pkg;

    localparam int unsigned OP_W        = 8;
    localparam int unsigned BRICK_W     = 2;
    localparam int unsigned BRICK_EXT_W = 3;
    localparam int unsigned SHIFT_W     = 3;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned N_W         = 3;

    typedef enum logic [1:0] {
        MODE_2B = 2'b00,
        MODE_4B = 2'b01,
        MODE_8B = 2'b10
    } mode_e;

    // Mode 11 falls through to the 8-bit case.
    function automatic logic [N_W-1:0] bricks_per_operand(logic [1:0] mode);
        case (mode)
            MODE_2B: return 3'd1;
            MODE_4B: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/bitbrick_decomposer_if.sv
// Operand-in / brick-out handshake bundle of the bitbrick decomposer.
interface bitbrick_decomposer_if;
    import bitfusion_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [OP_W-1:0]        in_a;
    logic [OP_W-1:0]        in_b;
    logic [1:0]             in_mode;
    logic                   in_sign_a;
    logic                   in_sign_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [BRICK_EXT_W-1:0] out_a;
    logic [BRICK_EXT_W-1:0] out_b;
    logic [SHIFT_W-1:0]     out_signal;
    logic                   out_last;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_sign_a, in_sign_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_signal, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_sign_a, in_sign_b, out_ready,
        output in_ready, out_valid, out_a, out_b, out_signal, out_last
    );

endinterface

// File: rtl/bitbrick_slice.sv
// Selects one 2-bit brick of an operand and extends it to 3 bits; only the
// top brick of a signed operand carries the sign.
module bitbrick_slice
    import bitfusion_pkg::*;
(
    input  logic [OP_W-1:0]        operand_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [N_W-1:0]         n_i,
    input  logic                   sign_i,
    output logic [BRICK_EXT_W-1:0] brick_o
);

    logic [BRICK_W-1:0] raw;
    logic               is_top;

    always_comb begin
        raw     = operand_i[{idx_i, 1'b0} +: BRICK_W];
        is_top  = ({1'b0, idx_i} == (n_i - 3'd1));
        brick_o = {sign_i & is_top & raw[1], raw};
    end

endmodule

// File: rtl/bitbrick_decomposer.sv
// Latches one operand pair and streams its n*n brick pairs with shift codes,
// A brick in the outer loop and B brick in the inner loop.
module bitbrick_decomposer
    import bitfusion_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    bitbrick_decomposer_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                 state_q, state_d;
    logic [OP_W-1:0]        a_q, a_d, b_q, b_d;
    logic [N_W-1:0]         n_q, n_d;
    logic                   sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [IDX_W-1:0]       i_q, i_d, j_q, j_d;
    logic                   out_valid_q, out_valid_d;
    logic [BRICK_EXT_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [SHIFT_W-1:0]     out_signal_q, out_signal_d;
    logic                   out_last_q, out_last_d;

    logic                   load_beat;
    logic [IDX_W-1:0]       last_idx_q, last_idx_d;
    logic [BRICK_EXT_W-1:0] brick_a, brick_b;

    always_comb begin
        last_idx_q = IDX_W'(n_q - 3'd1);
        last_idx_d = IDX_W'(n_d - 3'd1);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        n_d       = n_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        i_d       = i_q;
        j_d       = j_q;
        load_beat = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d       = bus.in_a;
                    b_d       = bus.in_b;
                    n_d       = bricks_per_operand(bus.in_mode);
                    sign_a_d  = bus.in_sign_a;
                    sign_b_d  = bus.in_sign_b;
                    i_d       = '0;
                    j_d       = '0;
                    state_d   = StIssue;
                    load_beat = 1'b1;
                end
            end
            StIssue: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        state_d = StIdle;
                    end else begin
                        load_beat = 1'b1;
                        if (j_q == last_idx_q) begin
                            j_d = '0;
                            i_d = i_q + 2'd1;
                        end else begin
                            j_d = j_q + 2'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Slices look at the next-state indices so the beat fields can be registered.
    bitbrick_slice u_slice_a (
        .operand_i (a_d),
        .idx_i     (i_d),
        .n_i       (n_d),
        .sign_i    (sign_a_d),
        .brick_o   (brick_a)
    );

    bitbrick_slice u_slice_b (
        .operand_i (b_d),
        .idx_i     (j_d),
        .n_i       (n_d),
        .sign_i    (sign_b_d),
        .brick_o   (brick_b)
    );

    always_comb begin
        out_valid_d  = (state_d == StIssue);
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_signal_d = out_signal_q;
        out_last_d   = out_last_q;
        if (load_beat) begin
            out_a_d      = brick_a;
            out_b_d      = brick_b;
            out_signal_d = {1'b0, i_d} + {1'b0, j_d};
            out_last_d   = (i_d == last_idx_d) && (j_d == last_idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            n_q          <= 3'd1;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            i_q          <= '0;
            j_q          <= '0;
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_signal_q <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            n_q          <= n_d;
            sign_a_q     <= sign_a_d;
            sign_b_q     <= sign_b_d;
            i_q          <= i_d;
            j_q          <= j_d;
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_signal_q <= out_signal_d;
            out_last_q   <= out_last_d;
        end
    end

    always_comb begin
        bus.in_ready   = (state_q == StIdle) && !rst;
        bus.out_valid  = out_valid_q;
        bus.out_a      = out_a_q;
        bus.out_b      = out_b_q;
        bus.out_signal = out_signal_q;
        bus.out_last   = out_last_q;
    end

endmodule

// File: tb/tb_bitbrick_decomposer.sv
// Directed bench for bitbrick_decomposer: vector table plus reset, stall and
// back-to-back sequences.
module tb_bitbrick_decomposer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bitbrick_decomposer_if bus ();

    bitbrick_decomposer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        logic       sa;
        logic       sb;
        int         beats;
        int         prod;
        logic [2:0] fa;
        logic [2:0] fb;
        logic [2:0] la;
        logic [2:0] lb;
        int         ls;
    } vec_t;

    typedef struct {
        int beats;
        int sum;
        int seq_err;
        int stall_err;
        int lasts;
        int fa, fb, fs, la, lb, ls;
    } res_t;

    int n_pass  = 0;
    int n_total = 0;
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mode_n(logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] ext_brick(logic [7:0] v, int x, int n, logic s);
        logic [1:0] br;
        br = v[2*x +: 2];
        return {(s && x == n - 1) ? br[1] : 1'b0, br};
    endfunction

    function automatic int sx3(logic [2:0] v);
        return v[2] ? int'(v) - 8 : int'(v);
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode,
                        input logic sa, input logic sb, input string tag);
        int w;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_mode   = mode;
        bus.in_sign_a = sa;
        bus.in_sign_b = sb;
        bus.in_valid  = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, " in_ready before accept"}, int'(bus.in_ready), 1);
        tick();
        // Operand inputs are don't-care once accepted.
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'($urandom);
        bus.in_b      = 8'($urandom);
        bus.in_mode   = 2'($urandom);
        check({tag, " out_valid one cycle after accept"}, int'(bus.out_valid), 1);
        check({tag, " in_ready low while issuing"}, int'(bus.in_ready), 0);
    endtask

    task automatic collect(input logic [7:0] a, input logic [7:0] b, input int n,
                           input logic sa, input logic sb, input int stall_beat,
                           input int stall_cyc, output res_t r);
        logic done;
        int   k, i, j;
        r = '{default: 0};
        done = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            if (bus.out_valid) begin
                if (r.beats == stall_beat) begin
                    logic [9:0] snap;
                    snap = {bus.out_a, bus.out_b, bus.out_signal, bus.out_last};
                    bus.out_ready = 1'b0;
                    for (int s = 0; s < stall_cyc; s++) begin
                        tick();
                        if (!bus.out_valid ||
                            snap != {bus.out_a, bus.out_b, bus.out_signal, bus.out_last})
                            r.stall_err++;
                    end
                    bus.out_ready = 1'b1;
                end
                k = r.beats;
                i = k / n;
                j = k % n;
                if (bus.out_a != ext_brick(a, i, n, sa) || bus.out_b != ext_brick(b, j, n, sb) ||
                    int'(bus.out_signal) != i + j || bus.out_last != (k == n * n - 1))
                    r.seq_err++;
                r.sum += sx3(bus.out_a) * sx3(bus.out_b) * (1 << (2 * int'(bus.out_signal)));
                if (k == 0) begin
                    r.fa = int'(bus.out_a);
                    r.fb = int'(bus.out_b);
                    r.fs = int'(bus.out_signal);
                end
                r.la = int'(bus.out_a);
                r.lb = int'(bus.out_b);
                r.ls = int'(bus.out_signal);
                if (bus.out_last) begin
                    r.lasts++;
                    done = 1'b1;
                end
                r.beats++;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        res_t r;
        int   n;

        //          a      b      mode   sa    sb   beats  prod    fa      fb      la      lb     ls
        vecs[0] = '{8'hB6, 8'h03, 2'b10, 1'b1, 1'b1, 16,   -222,   3'b010, 3'b011, 3'b110, 3'b000, 6};
        vecs[1] = '{8'h03, 8'h01, 2'b00, 1'b1, 1'b1, 1,    -1,     3'b111, 3'b001, 3'b111, 3'b001, 0};
        vecs[2] = '{8'h0F, 8'h0F, 2'b01, 1'b0, 1'b0, 4,    225,    3'b011, 3'b011, 3'b011, 3'b011, 2};
        vecs[3] = '{8'h80, 8'h7F, 2'b11, 1'b1, 1'b1, 16,   -16256, 3'b000, 3'b011, 3'b110, 3'b001, 6};
        vecs[4] = '{8'hFF, 8'hFF, 2'b10, 1'b0, 1'b0, 16,   65025,  3'b011, 3'b011, 3'b011, 3'b011, 6};
        vecs[5] = '{8'hA9, 8'h56, 2'b01, 1'b1, 1'b1, 4,    -42,    3'b001, 3'b010, 3'b110, 3'b001, 2};
        vecs[6] = '{8'hFE, 8'h03, 2'b00, 1'b0, 1'b0, 1,    6,      3'b010, 3'b011, 3'b010, 3'b011, 0};
        vecs[7] = '{8'hFF, 8'hFF, 2'b10, 1'b1, 1'b0, 16,   -255,   3'b011, 3'b011, 3'b111, 3'b011, 6};

        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.in_mode   = 2'b00;
        bus.in_sign_a = 1'b0;
        bus.in_sign_b = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;

        tick();
        check("reset in_ready", int'(bus.in_ready), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_signal", int'(bus.out_signal), 0);
        check("reset out_last", int'(bus.out_last), 0);
        tick();
        rst = 1'b0;
        #1;
        check("in_ready after reset release", int'(bus.in_ready), 1);
        tick();

        foreach (vecs[v]) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            n = mode_n(vecs[v].mode);
            send(vecs[v].a, vecs[v].b, vecs[v].mode, vecs[v].sa, vecs[v].sb, tag);
            collect(vecs[v].a, vecs[v].b, n, vecs[v].sa, vecs[v].sb, -1, 0, r);
            check({tag, " beats"}, r.beats, vecs[v].beats);
            check({tag, " reconstructed sum"}, r.sum, vecs[v].prod);
            check({tag, " beat sequence errors"}, r.seq_err, 0);
            check({tag, " out_last count"}, r.lasts, 1);
            check({tag, " first out_a"}, r.fa, int'(vecs[v].fa));
            check({tag, " first out_b"}, r.fb, int'(vecs[v].fb));
            check({tag, " first out_signal"}, r.fs, 0);
            check({tag, " last out_a"}, r.la, int'(vecs[v].la));
            check({tag, " last out_b"}, r.lb, int'(vecs[v].lb));
            check({tag, " last out_signal"}, r.ls, vecs[v].ls);
            check({tag, " idle out_valid"}, int'(bus.out_valid), 0);
            check({tag, " idle in_ready"}, int'(bus.in_ready), 1);
        end

        // Backpressure: stall three cycles on beat 5.
        send(8'hB6, 8'h03, 2'b10, 1'b1, 1'b1, "stall");
        collect(8'hB6, 8'h03, 4, 1'b1, 1'b1, 5, 3, r);
        check("stall outputs stable", r.stall_err, 0);
        check("stall beats", r.beats, 16);
        check("stall sum", r.sum, -222);
        check("stall sequence errors", r.seq_err, 0);

        // Reset while beat 7 is on the bus.
        send(8'hB6, 8'h03, 2'b10, 1'b1, 1'b1, "midrst");
        bus.out_ready = 1'b1;
        repeat (7) tick();
        check("midrst beat7 out_signal", int'(bus.out_signal), 4);
        check("midrst beat7 out_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        check("midrst in_ready during reset", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        check("midrst out_valid after reset edge", int'(bus.out_valid), 0);
        rst = 1'b0;
        #1;
        check("midrst in_ready after release", int'(bus.in_ready), 1);
        tick();
        check("midrst no stray beat", int'(bus.out_valid), 0);
        send(8'h0F, 8'h0F, 2'b01, 1'b0, 1'b0, "postrst");
        collect(8'h0F, 8'h0F, 2, 1'b0, 1'b0, -1, 0, r);
        check("postrst first out_signal", r.fs, 0);
        check("postrst beats", r.beats, 4);
        check("postrst sum", r.sum, 225);
        check("postrst sequence errors", r.seq_err, 0);

        // Back-to-back pairs with in_valid held high and a mode change.
        tick();
        bus.in_a      = 8'h03;
        bus.in_b      = 8'h01;
        bus.in_mode   = 2'b00;
        bus.in_sign_a = 1'b1;
        bus.in_sign_b = 1'b1;
        bus.in_valid  = 1'b1;
        check("b2b in_ready before first", int'(bus.in_ready), 1);
        tick();
        bus.in_a      = 8'h0F;
        bus.in_b      = 8'h0F;
        bus.in_mode   = 2'b01;
        bus.in_sign_a = 1'b0;
        bus.in_sign_b = 1'b0;
        bus.out_ready = 1'b1;
        check("b2b pair1 out_valid", int'(bus.out_valid), 1);
        check("b2b pair1 out_a", int'(bus.out_a), 7);
        check("b2b pair1 out_b", int'(bus.out_b), 1);
        check("b2b pair1 out_last", int'(bus.out_last), 1);
        tick();
        check("b2b bubble out_valid", int'(bus.out_valid), 0);
        check("b2b bubble in_ready", int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b pair2 out_valid after one bubble", int'(bus.out_valid), 1);
        collect(8'h0F, 8'h0F, 2, 1'b0, 1'b0, -1, 0, r);
        check("b2b pair2 beats", r.beats, 4);
        check("b2b pair2 sum", r.sum, 225);
        check("b2b pair2 sequence errors", r.seq_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bitbrick_decomposer.md
# bitbrick_decomposer

Operand-side sequencer for the bit-fusion multiplier. It accepts one pair of signed or unsigned operands at 2-, 4- or 8-bit precision and splits each operand into 2-bit bricks. It then streams every brick pair, one per cycle, with the 3-bit shift code that the bitbrick product shifter consumes downstream. The shift code steers the left shift of each 6-bit brick product into the 16-bit accumulation.

## Interface
- OP_W, 8: operand width; only 8 is supported.
- BRICK_W, 2: brick width; only 2 is supported.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  8  operand A; only in_a[2n-1:0] is used, where n = bricks per operand.
- in_b  in  8  operand B; same rule as in_a.
- in_mode  in  2  precision: 00 = 2-bit (n=1), 01 = 4-bit (n=2), 10 = 8-bit (n=4), 11 = treated as 10.
- in_sign_a  in  1  operand A is signed.
- in_sign_b  in  1  operand B is signed.
- out_valid  out  1  brick pair valid.
- out_ready  in  1  downstream accepts the brick pair.
- out_a  out  3  extended brick of A.
- out_b  out  3  extended brick of B.
- out_signal  out  3  shift code i+j; downstream shifts left by 2*out_signal.
- out_last  out  1  final beat of the current operand pair.

## Operation
- **FSM states:**
  - IDLE: in_ready=1, out_valid=0.
  - ISSUE: in_ready=0, out_valid=1.
- **IDLE -> ISSUE:** on in_valid && in_ready. The block latches in_a, in_b, the decoded n, in_sign_a and in_sign_b, and clears counters i and j.
- **Beat ordering:** i indexes the A brick (outer loop) and j indexes the B brick (inner loop). Both are 2-bit counters. Beat k uses i = k / n and j = k % n. Total beats per pair = n*n, i.e. 1, 4 or 16.
- **Brick extension:**
  - Brick x of an operand is bits [2x+1:2x].
  - The top brick (x = n-1) of a signed operand is sign-extended: bit 2 = bit 1.
  - All other bricks, and every brick of an unsigned operand, are zero-extended: bit 2 = 0.
- **Output fields:** out_signal = i + j, range 0..6. out_last = (i == n-1) && (j == n-1).
- **Advance:** on out_valid && out_ready, j increments. When j = n-1, j wraps to 0 and i increments.
- **ISSUE -> IDLE:** on the handshake of the out_last beat.
- **Stall:** while out_valid && !out_ready, all out_* fields hold stable.
- **Arithmetic invariant:** the sum over all beats of (signed out_a * signed out_b) << (2*out_signal) equals the exact product of the operands.
- **Mode 11:** identical in behaviour to mode 10.

## Timing
- **Reset:**
  - While rst=1, in_ready=0.
  - At the first edge with rst=1: state becomes IDLE; out_valid, out_a, out_b, out_signal and out_last become 0; i and j become 0.
  - in_ready=1 in the cycle after rst falls.
- **Reset mid-sequence:** the current pair is abandoned with no further beats. out_valid is 0 after the reset edge.
- **Latency:** operand accepted at edge T; first beat presented with out_valid=1 after edge T, i.e. visible in cycle T+1.
- **Throughput:** one beat per cycle while out_ready=1. Per-pair occupancy is n*n+1 cycles, because of one IDLE bubble between pairs.
- **Registered outputs:** all outputs are registered except in_ready, which decodes directly from the state.
- **Input stability:** in_* are ignored outside the accept handshake and need not be held stable.

## Structure
- **Shared package bitfusion_pkg** holds:
  - the precision mode enum (MODE_2B, MODE_4B, MODE_8B);
  - BRICK_W = 2;
  - BRICK_EXT_W = 3;
  - SHIFT_W = 3;
  - function bricks_per_operand(mode).
- **Sub-module bitbrick_slice:** combinational. Inputs: operand, brick index, n, sign flag. Output: the 3-bit extended brick. It is instantiated once for A and once for B.

## Test plan
- **Mode 10, signed, in_a=8'b1011_0110 (-74), in_b=8'd3:**
  - 16 beats.
  - The A sequence (i=0..3) is 010, 001, 011, 110.
  - Beat 0: out_a=010, out_b=011, out_signal=0.
  - Beat 15: out_a=110, out_b=000, out_signal=6, out_last=1.
  - Reconstructed sum = -222.
- **Mode 00, signed:** in_a=2'b11, in_b=2'b01. Expect a single beat: out_a=111, out_b=001, out_signal=0, out_last=1. Product = -1.
- **Mode 01, unsigned:** in_a=4'hF, in_b=4'hF. Expect 4 beats, all bricks 011, signals 0,1,1,2. Reconstructed sum = 225.
- **Backpressure:** in mode 10, hold out_ready=0 for 3 cycles at beat 5. Outputs stay stable and the beat count remains 16.
- **Reset at beat 7 of 16:** out_valid=0 next cycle and in_ready=1 after rst falls. A new pair then runs a fresh sequence starting at signal 0.
- **Back-to-back pairs with in_valid held high:** exactly one IDLE cycle separates the two pairs. The second pair's operands are latched correctly, and in_mode changes between pairs are honoured.
